// File: rtl/det_sched_if.sv
// Requester, response and detector-side signals of det_sched bundled as one interface.
// rsp_drop exists only when DET_SCHED_TIMEOUT_EN is defined.
interface det_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = $clog2(DATA_W + 1)
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [CNT_W-1:0]          rsp_count;
    logic                      busy;
    logic                      det_rstn;
    logic                      det_in;
    logic                      det_out;
`ifdef DET_SCHED_TIMEOUT_EN
    logic                      rsp_drop;

    modport slave (
        input  req_valid, req_data, rsp_ready, det_out,
        output req_ready, rsp_valid, rsp_id, rsp_count, busy, det_rstn, det_in, rsp_drop
    );
    modport master (
        output req_valid, req_data, rsp_ready, det_out,
        input  req_ready, rsp_valid, rsp_id, rsp_count, busy, det_rstn, det_in, rsp_drop
    );
`else
    modport slave (
        input  req_valid, req_data, rsp_ready, det_out,
        output req_ready, rsp_valid, rsp_id, rsp_count, busy, det_rstn, det_in
    );
    modport master (
        output req_valid, req_data, rsp_ready, det_out,
        input  req_ready, rsp_valid, rsp_id, rsp_count, busy, det_rstn, det_in
    );
`endif
endinterface

// File: rtl/det_sched.sv
// Round-robin scheduler time-sharing one external 1011 serial detector between NUM_REQ requesters.
// Optional response timeout with sticky rsp_drop: define DET_SCHED_TIMEOUT_EN.
module det_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = $clog2(DATA_W + 1),
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rstn,
    det_sched_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int K_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [ID_W:0] NREQ_C = (ID_W + 1)'(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("det_sched: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [K_W-1:0]    k_q, k_d;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [ID_W:0]     cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // First valid requester searching upward from ptr_q+1, wrapping at NUM_REQ.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (ID_W + 1)'(ptr_q) + (ID_W + 1)'(off);
            if (cand >= NREQ_C) cand = cand - NREQ_C;
            if (!gnt_any && bus.req_valid[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

`ifdef DET_SCHED_TIMEOUT_EN
    localparam int W_W = $clog2(TIMEOUT + 1);
    logic [W_W-1:0] wait_q, wait_d;
    logic           drop_q, drop_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
`ifdef DET_SCHED_TIMEOUT_EN
        wait_d  = '0;
        drop_d  = drop_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = CLR;
                    ptr_d   = gnt_idx;
                    id_d    = gnt_idx;
                    word_d  = data_arr[gnt_idx];
                    cnt_d   = '0;
                    k_d     = '0;
                end
            end
            CLR: state_d = SHIFT;
            SHIFT: begin
                // det_out in shift cycle 0 still reflects the cleared detector, so it is ignored.
                if (bus.det_out && k_q != '0) cnt_d = cnt_q + 1'b1;
                word_d = {word_q[DATA_W-2:0], 1'b0};
                k_d    = k_q + 1'b1;
                if (k_q == K_W'(DATA_W - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.det_out) cnt_d = cnt_q + 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
`ifdef DET_SCHED_TIMEOUT_EN
                else if (wait_q == W_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
`ifdef DET_SCHED_TIMEOUT_EN
            wait_q  <= '0;
            drop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
`ifdef DET_SCHED_TIMEOUT_EN
            wait_q  <= wait_d;
            drop_q  <= drop_d;
`endif
        end
    end

    // rstn gates the combinational outputs so they show reset values while reset is held.
    assign bus.req_ready = (rstn && state_q == IDLE && gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign bus.det_rstn  = rstn && (state_q != CLR);
    assign bus.det_in    = (state_q == SHIFT) && word_q[DATA_W-1];
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_count = cnt_q;
`ifdef DET_SCHED_TIMEOUT_EN
    assign bus.rsp_drop  = drop_q;
`endif
endmodule

// File: tb/tb_det_sched.sv
// Scoreboard bench for det_sched with a behavioural 1011 Moore detector (overlapping matches).
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares.
module tb_det_sched;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    det_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    det_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // External detector: synchronous active-low reset, match flag is the S1011 state.
    typedef enum logic [2:0] {D0, D1, D10, D101, D1011} dstate_t;
    dstate_t dst = D0;
    always @(posedge clk) begin
        if (!bus.det_rstn) dst <= D0;
        else begin
            case (dst)
                D0:      dst <= bus.det_in ? D1    : D0;
                D1:      dst <= bus.det_in ? D1    : D10;
                D10:     dst <= bus.det_in ? D101  : D0;
                D101:    dst <= bus.det_in ? D1011 : D10;
                default: dst <= bus.det_in ? D1    : D10;
            endcase
        end
    end
    assign bus.det_out = (dst == D1011);

    logic              req_v [NUM_REQ];
    logic [DATA_W-1:0] req_w [NUM_REQ];
    logic              rsp_rdy = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_drv
            assign bus.req_valid[gi]                 = req_v[gi];
            assign bus.req_data[gi*DATA_W +: DATA_W] = req_w[gi];
        end
    endgenerate
    assign bus.rsp_ready = rsp_rdy;

    int exp_gnt_q[$];
    int exp_id_q[$];
    int exp_cnt_q[$];

    int   cyc = 0;
    int   g_cyc = 0;
    logic prev_valid = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.req_ready != '0) begin
                chk("gnt_onehot", $countones(bus.req_ready), 1);
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 32'(bus.req_ready), 0);
                else chk("gnt_id", 32'(bus.req_ready), 32'(1) << exp_gnt_q.pop_front());
                $display("grant req_ready=%b cyc=%0d", bus.req_ready, cyc);
                g_cyc <= cyc;
            end
            if (bus.rsp_valid && !prev_valid) chk("latency", cyc - g_cyc, DATA_W + 3);
            if (bus.rsp_valid && bus.rsp_ready) begin
                $display("rsp id=%0d count=%0d cyc=%0d", bus.rsp_id, bus.rsp_count, cyc);
                if (exp_id_q.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
                else begin
                    chk("rsp_id", 32'(bus.rsp_id), exp_id_q.pop_front());
                    chk("rsp_count", 32'(bus.rsp_count), exp_cnt_q.pop_front());
                end
            end
        end
        prev_valid <= bus.rsp_valid;
    end

    function automatic void expect_job(input int id, input int cnt);
        exp_gnt_q.push_back(id);
        exp_id_q.push_back(id);
        exp_cnt_q.push_back(cnt);
    endfunction

    // Hold a request until acked, then drop it one cycle later.
    task automatic agent(input int i, input logic [DATA_W-1:0] w);
        logic acked;
        acked = 1'b0;
        req_w[2'(i)] = w;
        req_v[2'(i)] = 1'b1;
        for (int c = 0; c < 400 && !acked; c++) begin
            @(negedge clk);
            if (bus.req_ready[2'(i)]) acked = 1'b1;
        end
        chk("ack_seen", 32'(acked), 1);
        @(posedge clk); #1;
        req_v[2'(i)] = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_id_q.size() != 0 || bus.busy) && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_in_time", 32'(c < 2000), 1);
    endtask

    task automatic wait_rsp_valid();
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("rsp_valid_seen", 32'(seen), 1);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_v[2'(i)] = 1'b1;
            req_w[2'(i)] = '0;
        end
        // Reset values with every requester already asking.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_count", 32'(bus.rsp_count), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_det_rstn", 32'(bus.det_rstn), 0);
        chk("rst_det_in", 32'(bus.det_in), 0);

        // Arbitration from reset: 0,1,2,3.
        expect_job(0, 1); expect_job(1, 3); expect_job(2, 1); expect_job(3, 5);
        rstn = 1'b1;
        fork
            agent(0, 16'hB000);
            agent(1, 16'hB6D0);
            agent(2, 16'h000B);
            agent(3, 16'hB6DB);
        join
        drain();

        // Only req1 and req3 held: 1,3,1,3.
        expect_job(1, 0); expect_job(3, 0); expect_job(1, 4); expect_job(3, 1);
        fork
            begin agent(1, 16'hFFFF); agent(1, 16'hBBBB); end
            begin agent(3, 16'h0000); agent(3, 16'h2C00); end
        join
        drain();

        // Single jobs, including back-to-back isolation and a last-bit match.
        expect_job(0, 1); agent(0, 16'hB000);
        expect_job(2, 3); agent(2, 16'hB6D0);
        expect_job(1, 0); agent(1, 16'h0005);
        expect_job(1, 0); agent(1, 16'h6000);
        expect_job(3, 1); agent(3, 16'h000B);
        expect_job(2, 5); agent(2, 16'hB6DB);
        drain();

        // Backpressure: response held 10+ cycles while req2 waits.
        rsp_rdy = 1'b0;
        expect_job(0, 1);
        agent(0, 16'hB000);
        req_w[2] = 16'hB6D0;
        req_v[2] = 1'b1;
        expect_job(2, 3);
        wait_rsp_valid();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_rsp_id", 32'(bus.rsp_id), 0);
            chk("bp_rsp_count", 32'(bus.rsp_count), 1);
            chk("bp_busy", 32'(bus.busy), 1);
            chk("bp_no_grant", 32'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(bus.rsp_valid), 0);
        chk("bp_release_busy", 32'(bus.busy), 0);
        chk("bp_release_grant", 32'(bus.req_ready), 32'h4);
        @(posedge clk); #1;
        req_v[2] = 1'b0;
        drain();

        // Reset mid-SHIFT: job discarded, pending req0 wins over req1 afterwards.
        exp_gnt_q.push_back(0);
        agent(0, 16'hB6DB);
        req_w[0] = 16'hBBBB; req_v[0] = 1'b1;
        req_w[1] = 16'h2C00; req_v[1] = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_count_nonzero", 32'(bus.rsp_count != '0), 1);
        chk("mid_det_in", 32'(bus.det_in), 1);
        rstn = 1'b0;
        #1;
        chk("mrst_req_ready", 32'(bus.req_ready), 0);
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_rsp_id", 32'(bus.rsp_id), 0);
        chk("mrst_rsp_count", 32'(bus.rsp_count), 0);
        chk("mrst_det_rstn", 32'(bus.det_rstn), 0);
        chk("mrst_det_in", 32'(bus.det_in), 0);
        repeat (2) @(posedge clk);
        #1;
        expect_job(0, 4); expect_job(1, 1);
        rstn = 1'b1;
        fork
            agent(0, 16'hBBBB);
            agent(1, 16'h2C00);
        join
        drain();

`ifdef DET_SCHED_TIMEOUT_EN
        // Response dropped after TIMEOUT cycles without rsp_ready.
        chk("drop_init", 32'(bus.rsp_drop), 0);
        rsp_rdy = 1'b0;
        exp_gnt_q.push_back(2);
        agent(2, 16'hB000);
        wait_rsp_valid();
        for (int c = 1; c < TIMEOUT; c++) begin
            @(negedge clk);
            chk("to_valid_held", 32'(bus.rsp_valid), 1);
            chk("to_drop_low", 32'(bus.rsp_drop), 0);
        end
        @(negedge clk);
        chk("to_valid_dropped", 32'(bus.rsp_valid), 0);
        chk("to_drop_set", 32'(bus.rsp_drop), 1);
        rsp_rdy = 1'b1;
        expect_job(3, 1);
        agent(3, 16'h000B);
        drain();
        chk("to_drop_sticky", 32'(bus.rsp_drop), 1);
`endif

        chk("sb_rsp_empty", exp_id_q.size(), 0);
        chk("sb_gnt_empty", exp_gnt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
